// File: rtl/mipi_frame_packer.sv
// mipi_frame_packer: emits FS header, ROW_NUM x (row header + COL_NUM pixels), FE header.
// Ports: clk, rst_n, start, pixel_data/valid/ready, mipi_data/valid/ready, busy, row_done, frame_done, row_count.
module mipi_frame_packer #(
  parameter int ROW_NUM    = 800,
  parameter int COL_NUM    = 1280,
  parameter int GAP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] pixel_data,
  input  logic       pixel_valid,
  output logic       pixel_ready,
  output logic [7:0] mipi_data,
  output logic       mipi_data_valid,
  input  logic       mipi_ready,
  output logic       busy,
  output logic       row_done,
  output logic       frame_done,
  output logic [9:0] row_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FS, S_GAP, S_RH, S_PIX, S_FE, S_DONE
  } state_t;

  localparam logic [10:0] COL_LAST = 11'(COL_NUM - 1);
  localparam logic [9:0]  ROW_MAX  = 10'(ROW_NUM);
  localparam logic [3:0]  GAP_LAST = 4'(GAP_CYCLES - 1);
  localparam bit          HAS_GAP  = (GAP_CYCLES != 0);

  state_t      state, state_nx;
  logic [1:0]  hdr_idx;
  logic [10:0] col_cnt;
  logic [3:0]  gap_cnt;
  logic        last_tag;

  logic        load;
  logic        hdr_last;
  logic        col_last;
  logic        gap_last;
  logic        rows_left;
  logic        pix_take;
  logic        is_hdr;
  state_t      seg_next;

  logic        ld_en;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_last;

  function automatic logic [7:0] hdr_byte(input state_t s, input logic [1:0] i);
    logic [31:0] w;
    logic [7:0]  b;
    unique case (1'b1)
      s == S_RH: w = 32'h2C00_0513;
      s == S_FE: w = 32'h0101_001D;
      default:   w = 32'h0001_001A;
    endcase
    unique case (i)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  // Output register advances when empty or being drained.
  assign load      = !mipi_data_valid | mipi_ready;
  assign hdr_last  = (hdr_idx == 2'd3);
  assign col_last  = (col_cnt == COL_LAST);
  assign gap_last  = (gap_cnt == GAP_LAST);
  assign rows_left = (row_count < ROW_MAX);
  assign is_hdr    = (state == S_FS) | (state == S_RH) | (state == S_FE);

  assign pixel_ready = (state == S_PIX) & load;
  assign pix_take    = pixel_ready & pixel_valid;
  assign busy        = (state != S_IDLE);

  // Where a header/row segment goes once finished; a zero gap is skipped.
  always_comb begin
    seg_next = S_GAP;
    if (!HAS_GAP) seg_next = rows_left ? S_RH : S_FE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (start) state_nx = S_FS;
      S_FS:   if (load && hdr_last) state_nx = seg_next;
      S_GAP:  if (gap_last) state_nx = rows_left ? S_RH : S_FE;
      S_RH:   if (load && hdr_last) state_nx = S_PIX;
      S_PIX:  if (pix_take && col_last) state_nx = seg_next;
      S_FE:   if (load && hdr_last) state_nx = S_DONE;
      S_DONE: if (mipi_data_valid && mipi_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    ld_en    = 1'b0;
    ld_valid = 1'b0;
    ld_data  = 8'h00;
    ld_last  = 1'b0;
    unique case (state)
      S_IDLE: begin
        ld_en    = start;
        ld_valid = 1'b1;
        ld_data  = hdr_byte(S_FS, 2'd0);
      end
      S_FS, S_RH, S_FE: begin
        ld_en    = load;
        ld_valid = 1'b1;
        ld_data  = hdr_byte(state, hdr_idx);
      end
      S_PIX: begin
        ld_en    = load;
        ld_valid = pixel_valid;
        ld_data  = pixel_data;
        ld_last  = pixel_valid & col_last;
      end
      default: begin
        ld_en    = load;
        ld_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mipi_data       <= 8'h00;
      mipi_data_valid <= 1'b0;
      last_tag        <= 1'b0;
      row_done        <= 1'b0;
      frame_done      <= 1'b0;
      row_count       <= 10'd0;
      col_cnt         <= 11'd0;
      gap_cnt         <= 4'd0;
      hdr_idx         <= 2'd0;
    end else begin
      if (ld_en) begin
        mipi_data_valid <= ld_valid;
        last_tag        <= ld_last;
        if (ld_valid) mipi_data <= ld_data;
      end
      // Flags fire the cycle after the tagged byte is accepted.
      row_done   <= mipi_data_valid & mipi_ready & last_tag;
      frame_done <= (state == S_DONE) & mipi_data_valid & mipi_ready;

      if (state == S_IDLE)     hdr_idx <= start ? 2'd1 : 2'd0;
      else if (is_hdr && load) hdr_idx <= hdr_idx + 2'd1;

      if (state == S_IDLE && start)
        row_count <= 10'd0;
      else if (state == S_RH && load && hdr_last && rows_left)
        row_count <= row_count + 10'd1;

      if (state == S_IDLE) col_cnt <= 11'd0;
      else if (pix_take)   col_cnt <= col_last ? 11'd0 : col_cnt + 11'd1;

      gap_cnt <= (state == S_GAP) ? gap_cnt + 4'd1 : 4'd0;
    end
  end

endmodule

// File: tb/tb_mipi_frame_packer.sv
// tb_mipi_frame_packer: directed bench for mipi_frame_packer.
// Small frame (2 rows x 8 pixels, gap 2); stream captured and compared to constants.
module tb_mipi_frame_packer;

  localparam int RN = 2;
  localparam int CN = 8;
  localparam int GC = 2;
  localparam int FLEN = 8 + RN * (4 + CN);

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] pixel_data;
  logic       pixel_valid;
  logic       pixel_ready;
  logic [7:0] mipi_data;
  logic       mipi_data_valid;
  logic       mipi_ready;
  logic       busy;
  logic       row_done;
  logic       frame_done;
  logic [9:0] row_count;

  mipi_frame_packer #(
    .ROW_NUM(RN), .COL_NUM(CN), .GAP_CYCLES(GC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .mipi_data(mipi_data),
    .mipi_data_valid(mipi_data_valid), .mipi_ready(mipi_ready),
    .busy(busy), .row_done(row_done), .frame_done(frame_done),
    .row_count(row_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Pixel source: incrementing bytes, advanced on each handshake.
  logic       pix_clr;
  logic [7:0] pix_next = 8'h00;
  int         pix_hs = 0;
  assign pixel_data = pix_next;

  always @(posedge clk) begin
    if (pix_clr) begin
      pix_next <= 8'h00;
      pix_hs   <= 0;
    end else if (pixel_valid && pixel_ready) begin
      pix_next <= pix_next + 8'h01;
      pix_hs   <= pix_hs + 1;
    end
  end

  // Output monitor, sampled mid-cycle.
  logic [7:0] got[$];
  int         got_t[$];
  int         cyc = 0;
  int         rd_cnt = 0;
  int         fd_cnt = 0;
  int         hold_viol = 0;
  int         bad_busy = 0;
  logic       hv_prev = 1'b0;
  logic [7:0] hd_prev = 8'h00;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (mipi_data_valid && mipi_ready) begin
        got.push_back(mipi_data);
        got_t.push_back(cyc);
      end
      if (row_done)   rd_cnt <= rd_cnt + 1;
      if (frame_done) fd_cnt <= fd_cnt + 1;
      if (frame_done && busy) bad_busy <= bad_busy + 1;
      if (hv_prev && !(mipi_data_valid && mipi_data == hd_prev))
        hold_viol <= hold_viol + 1;
      hv_prev <= mipi_data_valid && !mipi_ready;
      hd_prev <= mipi_data;
    end else begin
      hv_prev <= 1'b0;
    end
  end

  logic [7:0] exp_s[FLEN];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic prep();
    pix_clr = 1'b1;
    step();
    pix_clr = 1'b0;
  endtask

  task automatic send_start(input string tag, output int base);
    base = got.size();
    mipi_ready = 1'b1;
    pixel_valid = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_valid"}, mipi_data_valid, 1);
    chk({tag, "_byte0"}, mipi_data, 8'h00);
  endtask

  task automatic wait_frame(input bit rnd, input bit starve, input bit extra);
    bit done = 1'b0;
    int left = 5;
    for (int i = 0; i < 3000 && !done; i++) begin
      mipi_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (starve && pix_hs == 3 && left > 0) begin
        pixel_valid = 1'b0;
        left--;
      end else begin
        pixel_valid = 1'b1;
      end
      start = (extra && (i == 3 || i == 10 || i == 20));
      step();
      if (frame_done) done = 1'b1;
    end
    start = 1'b0;
    mipi_ready = 1'b1;
    chk("frame_timeout", done, 1);
  endtask

  function automatic int stream_mis(input int base);
    int m = 0;
    if (got.size() < base + FLEN) return 999;
    for (int i = 0; i < FLEN; i++)
      if (got[base + i] !== exp_s[i]) m++;
    return m;
  endfunction

  function automatic int gap_mis(input int base);
    int m = 0;
    int d;
    int e;
    if (got_t.size() < base + FLEN) return 999;
    for (int i = 1; i < FLEN; i++) begin
      d = got_t[base + i] - got_t[base + i - 1];
      e = (i == 4 || i == 16 || i == 28) ? GC + 1 : 1;
      if (d != e) m++;
    end
    return m;
  endfunction

  initial begin
    int b;
    int b2;
    int rd0;
    int fd0;
    int hv0;
    int k;

    // Expected stream: FS, (RH, 8 pixels) x2, FE.
    exp_s[0] = 8'h00; exp_s[1] = 8'h01; exp_s[2] = 8'h00; exp_s[3] = 8'h1A;
    for (int r = 0; r < RN; r++) begin
      exp_s[4 + r*12] = 8'h2C; exp_s[5 + r*12] = 8'h00;
      exp_s[6 + r*12] = 8'h05; exp_s[7 + r*12] = 8'h13;
      for (int c = 0; c < CN; c++) exp_s[8 + r*12 + c] = 8'(r*CN + c);
    end
    exp_s[28] = 8'h01; exp_s[29] = 8'h01; exp_s[30] = 8'h00; exp_s[31] = 8'h1D;

    rst_n = 1'b0;
    start = 1'b0;
    pixel_valid = 1'b0;
    mipi_ready = 1'b1;
    pix_clr = 1'b1;
    idle(3);
    chk("rst_data", mipi_data, 0);
    chk("rst_valid", mipi_data_valid, 0);
    chk("rst_pready", pixel_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_row_done", row_done, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_row_count", row_count, 0);
    rst_n = 1'b1;
    pix_clr = 1'b0;
    idle(2);

    // Smoke frame.
    prep();
    rd0 = rd_cnt; fd0 = fd_cnt; hv0 = hold_viol;
    send_start("smoke", b);
    wait_frame(1'b0, 1'b0, 1'b0);
    chk("smoke_busy_at_done", busy, 0);
    idle(5);
    chk("smoke_stream", stream_mis(b), 0);
    chk("smoke_gaps", gap_mis(b), 0);
    chk("smoke_len", got.size() - b, FLEN);
    chk("smoke_row_done", rd_cnt - rd0, 2);
    chk("smoke_frame_done", fd_cnt - fd0, 1);
    chk("smoke_row_count", row_count, 2);
    chk("smoke_pix_hs", pix_hs, 16);

    // Random downstream backpressure.
    prep();
    rd0 = rd_cnt; fd0 = fd_cnt; hv0 = hold_viol;
    send_start("bp", b);
    wait_frame(1'b1, 1'b0, 1'b0);
    idle(5);
    chk("bp_stream", stream_mis(b), 0);
    chk("bp_len", got.size() - b, FLEN);
    chk("bp_hold", hold_viol - hv0, 0);
    chk("bp_pix_hs", pix_hs, 16);
    chk("bp_row_done", rd_cnt - rd0, 2);
    chk("bp_frame_done", fd_cnt - fd0, 1);

    // Upstream starvation for 5 cycles after the third pixel.
    prep();
    send_start("starve", b);
    wait_frame(1'b0, 1'b1, 1'b0);
    idle(5);
    chk("starve_stream", stream_mis(b), 0);
    chk("starve_len", got.size() - b, FLEN);
    if (got_t.size() >= b + 12)
      chk("starve_bubble", got_t[b + 11] - got_t[b + 10], 6);
    else
      chk("starve_bubble", got_t.size(), b + 12);

    // Start pulses while busy are dropped; start right after frame_done.
    prep();
    fd0 = fd_cnt;
    send_start("rs", b);
    wait_frame(1'b0, 1'b0, 1'b1);
    chk("rs_one_frame", got.size() - b, FLEN);
    chk("rs_stream", stream_mis(b), 0);
    pix_clr = 1'b1;
    send_start("rs_again", b2);
    pix_clr = 1'b0;
    wait_frame(1'b0, 1'b0, 1'b0);
    idle(8);
    chk("rs_again_stream", stream_mis(b2), 0);
    chk("rs_again_len", got.size() - b2, FLEN);
    chk("rs_frames", fd_cnt - fd0, 2);
    chk("rs_idle_busy", busy, 0);
    chk("busy_with_frame_done", bad_busy, 0);

    // Asynchronous reset mid-row.
    prep();
    send_start("mid", b);
    k = 0;
    while (pix_hs < 3 && k < 100) begin
      step();
      k++;
    end
    chk("mid_reach_row", pix_hs >= 3, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", mipi_data_valid, 0);
    chk("mid_rst_data", mipi_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pready", pixel_ready, 0);
    chk("mid_rst_row_count", row_count, 0);
    step();
    rst_n = 1'b1;
    idle(2);
    chk("mid_no_output", mipi_data_valid, 0);
    prep();
    send_start("mid_restart", b);
    wait_frame(1'b0, 1'b0, 1'b0);
    idle(5);
    chk("mid_restart_stream", stream_mis(b), 0);
    chk("mid_restart_len", got.size() - b, FLEN);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mipi_frame_packer.md
# mipi_frame_packer

Byte-stream frame generator that produces the MIPI-style packet sequence consumed by the image-extraction path. It emits a frame-start header, then `ROW_NUM` rows, each made of a row header followed by `COL_NUM` pixel bytes, then a frame-end header. It sits between a pixel source (test-pattern generator or replay buffer) and the byte link feeding the receiver. It is used for loopback test, bring-up and simulation of the receive side.

## Interface
Parameters:
- `ROW_NUM`, 800, rows per frame.
- `COL_NUM`, 1280, pixel bytes per row.
- `GAP_CYCLES`, 4, idle cycles (`mipi_data_valid`=0) inserted after the frame-start header and after each row; range 0..15.

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `start`  in  1  one-cycle request to send a frame; ignored while `busy`=1.
- `pixel_data`  in  8  upstream pixel byte.
- `pixel_valid`  in  1  upstream byte valid.
- `pixel_ready`  out  1  block takes `pixel_data` on a cycle with `pixel_valid & pixel_ready`.
- `mipi_data`  out  8  output byte.
- `mipi_data_valid`  out  1  output byte valid.
- `mipi_ready`  in  1  downstream accepts on a cycle with `mipi_data_valid & mipi_ready`.
- `busy`  out  1  high from the cycle after `start` is accepted until `frame_done`.
- `row_done`  out  1  one-cycle pulse when the last pixel byte of a row is accepted downstream.
- `frame_done`  out  1  one-cycle pulse when the last frame-end byte is accepted downstream.
- `row_count`  out  10  rows whose header has been emitted in the current frame.

## Operation
- Output is a single register stage.
  - A "load" happens on a cycle where `!mipi_data_valid | mipi_ready`.
  - While `mipi_data_valid=1 & mipi_ready=0`, `mipi_data` and `mipi_data_valid` hold unchanged.
- Headers are sent MSB byte first:
  - frame start 0x00,0x01,0x00,0x1A
  - row start 0x2C,0x00,0x05,0x13
  - frame end 0x01,0x01,0x00,0x1D
- States:
  - IDLE: `start` -> FS_HDR; clears `row_count` and the byte index.
  - FS_HDR: loads the 4 frame-start bytes on successive loads. After the 4th load -> GAP.
  - GAP: counts `GAP_CYCLES` cycles, with no load of valid data. Then -> ROW_HDR if `row_count < ROW_NUM`, else -> FE_HDR. With `GAP_CYCLES`=0 it is skipped (direct transition).
  - ROW_HDR: loads 4 row-start bytes; on the 4th, `row_count` increments -> PIXELS.
  - PIXELS: `pixel_ready = load condition` (combinational from state and the output register).
    - Each accepted pixel is loaded into the output register.
    - Column counter (11 bit) counts accepted pixels; at `COL_NUM` -> GAP.
    - If `pixel_valid`=0, `mipi_data_valid` falls after the current byte is accepted (bubble). No padding, no header.
  - FE_HDR: loads 4 frame-end bytes -> DONE_WAIT.
  - DONE_WAIT: waits for acceptance of the 0x1D byte, pulses `frame_done` -> IDLE.
- `pixel_ready`=0 in every state except PIXELS.
- Pixels offered outside PIXELS are not consumed.
- `start` while `busy`=1 is dropped, not queued.

## Timing
- Reset values: `mipi_data`=0, `mipi_data_valid`=0, `pixel_ready`=0, `busy`=0, `row_done`=0, `frame_done`=0, `row_count`=0, state IDLE.
- Assertion of `rst_n`=0 mid-frame aborts immediately, with outputs at reset values. No frame-end is sent.
- `start` at cycle N (IDLE): `busy`=1 and `mipi_data_valid`=1 with 0x00 at N+1.
- With `mipi_ready` held 1 and no gap:
  - The frame-start header occupies N+1..N+4.
  - The first row header begins at N+5+`GAP_CYCLES`.
- Pixel latency: byte accepted at cycle M appears on `mipi_data` at M+1.
- Total valid bytes per frame = 8 + `ROW_NUM`*(4+`COL_NUM`).
- `row_done` and `frame_done` are asserted in the cycle after the accepting handshake. `busy` falls in the same cycle `frame_done` is high.
- `row_count` saturates at `ROW_NUM`; the column counter resets to 0 on entering GAP.
- Simultaneous `mipi_ready`=0 and `pixel_valid`=1: no pixel is consumed, and the byte is held.

## Test plan
- Smoke test:
  - Stimulus: `ROW_NUM`=2, `COL_NUM`=8, `GAP_CYCLES`=2, `mipi_ready`=1, incrementing pixels 0..15, `start` pulse.
  - Required stream: 00 01 00 1A, 2 idle, 2C 00 05 13, 00..07, 2 idle, 2C 00 05 13, 08..0F, 2 idle, 01 01 00 1D.
  - Required flags: `row_done` pulses ×2, `frame_done` ×1, `row_count`=2.
- Backpressure:
  - Stimulus: random `mipi_ready` (50%).
  - Required: output byte sequence identical to the smoke test. No byte changes while `valid & !ready`. Count of pixel handshakes = 16.
- Upstream starvation:
  - Stimulus: `pixel_valid` low for 5 cycles mid-row.
  - Required: `mipi_data_valid`=0 bubble of 5 cycles, no extra bytes, row still exactly `COL_NUM` bytes.
- Restart rules:
  - Stimulus: `start` pulsed while `busy`.
  - Required: ignored, exactly one frame emitted.
  - Stimulus: `start` on the cycle after `frame_done`.
  - Required: new frame begins with 0x00 on the next cycle.
- Reset mid-row:
  - Stimulus: `rst_n` low during a row.
  - Required: outputs at reset values immediately. After release plus `start`, the stream restarts cleanly from 00 01 00 1A.
- Loopback:
  - Stimulus: default parameters, output fed into the image-extraction receiver.
  - Required: 800 rows of 1280 pixels recovered bit-exact.
